dynaq_episode_sequencer: RTL and testbench
==========================================

# dynaq_episode_sequencer

Episode scheduler for the Dyna-Q agent, placed between the board controls (start/next keys, start-location switches) and the Q-learning datapath. It owns the shared learner/Q-table datapath and interleaves it: one real environment step, then N_PLAN model-based planning updates, repeated until the goal is reached or the step budget runs out. It then emits a per-episode step count for the UART reporter and waits for the next-episode key.

## Interface
- N_PLAN, 5: planning updates issued after each real step; 0 disables planning.
- MAX_STEPS, 100: real-step budget per episode; range 1..255.
- NUM_STATES, 25: number of grid states; start locations at or above this value map to 0.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse, already debounced; starts the first episode
- next_i  in  1  one-cycle pulse; starts the next episode after a report
- start_location  in  5  episode start state, sampled on accepted start_i/next_i
- cmd_valid  out  1  step command to the datapath
- cmd_mode  out  1  0 = real step, 1 = planning update
- cmd_state  out  5  current agent state (real steps only; 0 when cmd_mode = 1)
- cmd_ready  in  1  datapath accepts the command
- done_valid  in  1  one-cycle completion pulse from the datapath
- done_next_state  in  5  resulting state (meaningful for real steps)
- done_goal  in  1  resulting state is terminal (meaningful for real steps)
- report_valid  out  1  episode result available
- report_data  out  8  real steps taken in the finished episode
- report_ready  in  1  reporter accepts
- busy  out  1  episode in progress, including the REPORT state
- episode_cnt  out  8  completed episodes; wraps modulo 256
- state_o  out  5  current agent state, drives the HEX display

## Operation
- FSM states: IDLE, REAL_ISSUE, REAL_WAIT, PLAN_ISSUE, PLAN_WAIT, REPORT, DONE.
- IDLE:
  - start_i loads cur_state from start_location (clamped to 0 if ≥ NUM_STATES).
  - Clears step_cnt and goal_flag.
  - Goes to REAL_ISSUE. next_i is ignored.
- REAL_ISSUE:
  - Drives cmd_valid = 1, cmd_mode = 0, cmd_state = cur_state.
  - Goes to REAL_WAIT on cmd_ready.
- REAL_WAIT:
  - On done_valid: cur_state ← done_next_state; step_cnt ← step_cnt + 1, saturating at 255; goal_flag ← done_goal; plan_cnt ← 0.
  - Goes to PLAN_ISSUE if N_PLAN > 0, otherwise to END_CHECK.
- PLAN_ISSUE:
  - Drives cmd_valid = 1, cmd_mode = 1.
  - Goes to PLAN_WAIT on cmd_ready.
- PLAN_WAIT:
  - On done_valid: if plan_cnt == N_PLAN−1, go to END_CHECK; otherwise plan_cnt++ and go to PLAN_ISSUE.
- END_CHECK is combinational, not a state:
  - If goal_flag is set or step_cnt == MAX_STEPS, go to REPORT.
  - Otherwise go to REAL_ISSUE.
- REPORT:
  - Drives report_valid = 1 and report_data = step_cnt.
  - On report_ready: episode_cnt++ and go to DONE.
- DONE:
  - next_i or start_i reloads cur_state from start_location (clamped), clears step_cnt and goal_flag, and goes to REAL_ISSUE.
- Once asserted, cmd_valid and report_valid hold with stable payload until accepted.
- done_valid outside REAL_WAIT/PLAN_WAIT is ignored.
- start_i/next_i outside IDLE/DONE is ignored.
- busy = 1 in every state except IDLE and DONE.

## Timing
- All outputs are registered or decoded from the state register (Moore). No combinational path runs from any input to any output.
- Reset (asynchronous, takes effect immediately): FSM = IDLE; cur_state, step_cnt, plan_cnt, goal_flag and episode_cnt = 0. All outputs are 0.
- start_i in cycle t: cmd_valid = 1 in cycle t+1.
- Handshake: the transfer occurs in a cycle with valid && ready; the next state is entered at the following edge.
- done_valid in cycle t: the next command's cmd_valid rises in cycle t+1, or report_valid does if the episode is over.
- With cmd_ready tied high and done_valid one cycle after acceptance, each real step plus its plan batch takes exactly 2·(1+N_PLAN) cycles.
- Reset mid-handshake drops cmd_valid/report_valid in the same cycle. No partial state survives.
- done_valid arriving in the same cycle as cmd_ready in an ISSUE state is ignored; the datapath must complete at least one cycle after acceptance.

## Test plan
- Reset, then start_i with start_location = 3. Datapath: ready = 1; done one cycle later, next_state = 24, goal = 1.
  - Required: one real command carrying cmd_state = 3, then exactly 5 cmd_mode = 1 commands, then report_data = 1, episode_cnt = 1, state_o = 24.
- Goal never reached, MAX_STEPS = 4.
  - Required: exactly 4 real and 20 planning commands, then report_data = 4. next_i restarts with step_cnt = 0.
- start_location = 30.
  - Required: first cmd_state = 0.
- cmd_ready held low for 10 cycles.
  - Required: cmd_valid, cmd_mode and cmd_state stable throughout, and exactly one transfer when ready rises. report_ready held low likewise keeps report_valid/report_data stable.
- Spurious done_valid in REAL_ISSUE, plus start_i/next_i pulses mid-episode.
  - Required: no state, counter or FSM change.
- Reset asserted during PLAN_WAIT.
  - Required: cmd_valid = 0, busy = 0 and episode_cnt = 0 immediately. The next start_i begins a fresh episode from start_location.

Source files
------------

// File: rtl/dynaq_episode_sequencer_if.sv
// Board keys, datapath command/completion and reporter handshakes of the Dyna-Q episode sequencer.
// master = sequencer side, slave = controls/datapath/reporter side.
interface dynaq_episode_sequencer_if;
  logic       start_i;
  logic       next_i;
  logic [4:0] start_location;
  logic       cmd_valid;
  logic       cmd_mode;
  logic [4:0] cmd_state;
  logic       cmd_ready;
  logic       done_valid;
  logic [4:0] done_next_state;
  logic       done_goal;
  logic       report_valid;
  logic [7:0] report_data;
  logic       report_ready;
  logic       busy;
  logic [7:0] episode_cnt;
  logic [4:0] state_o;

  modport master (
    input  start_i, next_i, start_location, cmd_ready, done_valid,
           done_next_state, done_goal, report_ready,
    output cmd_valid, cmd_mode, cmd_state, report_valid, report_data,
           busy, episode_cnt, state_o
  );

  modport slave (
    output start_i, next_i, start_location, cmd_ready, done_valid,
           done_next_state, done_goal, report_ready,
    input  cmd_valid, cmd_mode, cmd_state, report_valid, report_data,
           busy, episode_cnt, state_o
  );
endinterface

// File: rtl/dynaq_episode_sequencer.sv
// Dyna-Q episode scheduler: one real step then N_PLAN planning updates until goal or budget; Moore outputs.
// Command and report are valid/ready and hold stable payload until accepted; completion takes >= 1 cycle.
module dynaq_episode_sequencer #(
  parameter int N_PLAN     = 5,
  parameter int MAX_STEPS  = 100,
  parameter int NUM_STATES = 25
) (
  input logic                        clk,
  input logic                        reset,
  dynaq_episode_sequencer_if.master  bus
);
  localparam int              PW        = (N_PLAN > 1) ? $clog2(N_PLAN) : 1;
  localparam logic [PW-1:0]   PLAN_LAST = PW'((N_PLAN > 0) ? N_PLAN - 1 : 0);
  localparam logic [7:0]      MAX_S     = 8'(MAX_STEPS);
  localparam logic [5:0]      NS        = 6'(NUM_STATES);

  typedef enum logic [2:0] {
    IDLE, REAL_ISSUE, REAL_WAIT, PLAN_ISSUE, PLAN_WAIT, REPORT, DONE
  } state_t;

  state_t         state, state_nxt;
  logic [4:0]     cur_state;
  logic [7:0]     step_cnt;
  logic [PW-1:0]  plan_cnt;
  logic           goal_flag;
  logic [7:0]     episode_cnt;

  logic           ep_load, real_done, plan_done, report_done;
  logic [7:0]     step_inc;
  logic [4:0]     start_clamped;

  assign step_inc      = (step_cnt == 8'hFF) ? step_cnt : step_cnt + 8'd1;
  assign start_clamped = ({1'b0, bus.start_location} >= NS) ? 5'd0 : bus.start_location;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ep_load     = 1'b0;
    real_done   = 1'b0;
    plan_done   = 1'b0;
    report_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          ep_load   = 1'b1;
          state_nxt = REAL_ISSUE;
        end
      end
      REAL_ISSUE: if (bus.cmd_ready) state_nxt = REAL_WAIT;
      REAL_WAIT: begin
        if (bus.done_valid) begin
          real_done = 1'b1;
          // Without planning the end check must see the values being written this cycle
          if (N_PLAN > 0)                                  state_nxt = PLAN_ISSUE;
          else if (bus.done_goal || step_inc == MAX_S)     state_nxt = REPORT;
          else                                             state_nxt = REAL_ISSUE;
        end
      end
      PLAN_ISSUE: if (bus.cmd_ready) state_nxt = PLAN_WAIT;
      PLAN_WAIT: begin
        if (bus.done_valid) begin
          if (plan_cnt == PLAN_LAST) begin
            if (goal_flag || step_cnt == MAX_S) state_nxt = REPORT;
            else                                state_nxt = REAL_ISSUE;
          end else begin
            plan_done = 1'b1;
            state_nxt = PLAN_ISSUE;
          end
        end
      end
      REPORT: begin
        if (bus.report_ready) begin
          report_done = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (bus.start_i || bus.next_i) begin
          ep_load   = 1'b1;
          state_nxt = REAL_ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= 5'd0;
      step_cnt    <= 8'd0;
      plan_cnt    <= '0;
      goal_flag   <= 1'b0;
      episode_cnt <= 8'd0;
    end else begin
      if (ep_load) begin
        cur_state <= start_clamped;
        step_cnt  <= 8'd0;
        goal_flag <= 1'b0;
      end
      if (real_done) begin
        cur_state <= bus.done_next_state;
        step_cnt  <= step_inc;
        goal_flag <= bus.done_goal;
        plan_cnt  <= '0;
      end
      if (plan_done)   plan_cnt    <= plan_cnt + PW'(1);
      if (report_done) episode_cnt <= episode_cnt + 8'd1;
    end
  end

  assign bus.cmd_valid    = (state == REAL_ISSUE) || (state == PLAN_ISSUE);
  assign bus.cmd_mode     = (state == PLAN_ISSUE);
  assign bus.cmd_state    = (state == REAL_ISSUE) ? cur_state : 5'd0;
  assign bus.report_valid = (state == REPORT);
  assign bus.report_data  = (state == REPORT) ? step_cnt : 8'd0;
  assign bus.busy         = (state != IDLE) && (state != DONE);
  assign bus.episode_cnt  = episode_cnt;
  assign bus.state_o      = cur_state;
endmodule

// File: tb/tb_dynaq_episode_sequencer.sv
// Directed bench for dynaq_episode_sequencer (N_PLAN=5, MAX_STEPS=4) with a one-cycle-latency datapath model.
module tb_dynaq_episode_sequencer;
  logic clk = 1'b0;
  logic reset;

  dynaq_episode_sequencer_if bus();

  dynaq_episode_sequencer #(
    .N_PLAN(5), .MAX_STEPS(4), .NUM_STATES(25)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int n_real     = 0;
  int n_plan     = 0;
  int first_real = -1;
  int bad_plan   = 0;

  logic       dp_spur = 1'b0;
  logic [4:0] dp_next = 5'd0;
  logic       dp_goal = 1'b0;

  // Datapath model: completes every accepted command exactly one cycle later
  initial begin : datapath
    logic acc_last, acc_mode;
    acc_last = 1'b0;
    acc_mode = 1'b0;
    bus.done_valid      = 1'b0;
    bus.done_next_state = 5'd0;
    bus.done_goal       = 1'b0;
    forever begin
      @(negedge clk);
      acc_last = bus.cmd_valid && bus.cmd_ready;
      acc_mode = bus.cmd_mode;
      if (acc_last) begin
        if (!bus.cmd_mode) begin
          if (n_real == 0) first_real = int'(bus.cmd_state);
          n_real++;
        end else begin
          n_plan++;
          if (bus.cmd_state !== 5'd0) bad_plan++;
        end
      end
      @(posedge clk); #1;
      bus.done_valid      = acc_last || dp_spur;
      bus.done_next_state = (acc_last && acc_mode) ? 5'd0 : dp_next;
      bus.done_goal       = (acc_last && acc_mode) ? 1'b0 : dp_goal;
    end
  end

  task automatic clear_log();
    n_real = 0; n_plan = 0; first_real = -1; bad_plan = 0;
  endtask

  task automatic pulse_key(input logic s, input logic n, input logic [4:0] loc);
    @(posedge clk); #1;
    bus.start_i = s; bus.next_i = n; bus.start_location = loc;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.next_i = 1'b0;
  endtask

  task automatic wait_report(input int budget, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      ok = (bus.report_valid === 1'b1);
    end
  endtask

  task automatic accept_report();
    @(posedge clk); #1; bus.report_ready = 1'b1;
    @(posedge clk); #1; bus.report_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_i = 1'b0; bus.next_i = 1'b0; bus.start_location = 5'd0;
    bus.cmd_ready = 1'b0; bus.report_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_valid: got %0d want 0", bus.cmd_valid); end
    vectors++; if (bus.report_valid !== 1'b0) begin miscompares++; $display("FAIL reset_report_valid: got %0d want 0", bus.report_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0d want 0", bus.busy); end
    vectors++; if (bus.episode_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_episode_cnt: got %0d want 0", bus.episode_cnt); end
    vectors++; if (bus.state_o !== 5'd0) begin miscompares++; $display("FAIL reset_state_o: got %0d want 0", bus.state_o); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_goal_first_step();
    int cyc; bit ok;
    clear_log(); dp_next = 5'd24; dp_goal = 1'b1; bus.cmd_ready = 1'b1;
    pulse_key(1'b1, 1'b0, 5'd3);
    vectors++; if (bus.cmd_valid !== 1'b1) begin miscompares++; $display("FAIL start_latency: cmd_valid %0d want 1", bus.cmd_valid); end
    vectors++; if (bus.cmd_state !== 5'd3) begin miscompares++; $display("FAIL first_cmd_state: got %0d want 3", bus.cmd_state); end
    wait_report(100, cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL goal_report_timeout: report_valid never rose within %0d cycles", cyc); end
    vectors++; if (cyc != 13) begin miscompares++; $display("FAIL goal_step_cycles: got %0d want 13", cyc); end
    vectors++; if (n_real != 1) begin miscompares++; $display("FAIL goal_real_cmds: got %0d want 1", n_real); end
    vectors++; if (first_real != 3) begin miscompares++; $display("FAIL goal_real_state: got %0d want 3", first_real); end
    vectors++; if (n_plan != 5) begin miscompares++; $display("FAIL goal_plan_cmds: got %0d want 5", n_plan); end
    vectors++; if (bad_plan != 0) begin miscompares++; $display("FAIL plan_cmd_state: %0d plan commands with nonzero state, want 0", bad_plan); end
    vectors++; if (bus.report_data !== 8'd1) begin miscompares++; $display("FAIL goal_report_data: got %0d want 1", bus.report_data); end
    vectors++; if (bus.state_o !== 5'd24) begin miscompares++; $display("FAIL goal_state_o: got %0d want 24", bus.state_o); end
    vectors++; if (bus.episode_cnt !== 8'd0) begin miscompares++; $display("FAIL episode_before_accept: got %0d want 0", bus.episode_cnt); end
    accept_report();
    vectors++; if (bus.episode_cnt !== 8'd1) begin miscompares++; $display("FAIL goal_episode_cnt: got %0d want 1", bus.episode_cnt); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL done_busy: got %0d want 0", bus.busy); end
    vectors++; if (bus.report_valid !== 1'b0) begin miscompares++; $display("FAIL done_report_valid: got %0d want 0", bus.report_valid); end
  endtask

  task automatic test_step_budget();
    int cyc; bit ok;
    clear_log(); dp_next = 5'd7; dp_goal = 1'b0;
    pulse_key(1'b0, 1'b1, 5'd10);
    vectors++; if (bus.cmd_state !== 5'd10) begin miscompares++; $display("FAIL next_cmd_state: got %0d want 10", bus.cmd_state); end
    wait_report(300, cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL budget_report_timeout: report_valid never rose within %0d cycles", cyc); end
    vectors++; if (cyc != 49) begin miscompares++; $display("FAIL budget_cycles: got %0d want 49", cyc); end
    vectors++; if (n_real != 4) begin miscompares++; $display("FAIL budget_real_cmds: got %0d want 4", n_real); end
    vectors++; if (n_plan != 20) begin miscompares++; $display("FAIL budget_plan_cmds: got %0d want 20", n_plan); end
    vectors++; if (bus.report_data !== 8'd4) begin miscompares++; $display("FAIL budget_report_data: got %0d want 4", bus.report_data); end
    vectors++; if (bus.state_o !== 5'd7) begin miscompares++; $display("FAIL budget_state_o: got %0d want 7", bus.state_o); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.report_valid, bus.report_data} !== {1'b1, 8'd4}) begin
        miscompares++;
        $display("FAIL report_stall cycle %0d: valid %0d data %0d want valid 1 data 4", i, bus.report_valid, bus.report_data);
      end
    end
    accept_report();
    vectors++; if (bus.episode_cnt !== 8'd2) begin miscompares++; $display("FAIL budget_episode_cnt: got %0d want 2", bus.episode_cnt); end
  endtask

  task automatic test_clamp_restart();
    int cyc; bit ok;
    clear_log(); dp_next = 5'd1; dp_goal = 1'b1;
    pulse_key(1'b0, 1'b1, 5'd30);
    vectors++; if (bus.cmd_state !== 5'd0) begin miscompares++; $display("FAIL clamp_cmd_state: got %0d want 0", bus.cmd_state); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL clamp_busy: got %0d want 1", bus.busy); end
    wait_report(100, cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL clamp_report_timeout: report_valid never rose within %0d cycles", cyc); end
    vectors++; if (bus.report_data !== 8'd1) begin miscompares++; $display("FAIL restart_step_cnt: got %0d want 1", bus.report_data); end
    vectors++; if (first_real != 0) begin miscompares++; $display("FAIL clamp_real_state: got %0d want 0", first_real); end
    accept_report();
    vectors++; if (bus.episode_cnt !== 8'd3) begin miscompares++; $display("FAIL clamp_episode_cnt: got %0d want 3", bus.episode_cnt); end
  endtask

  task automatic test_ready_stall();
    int cyc; bit ok;
    clear_log(); bus.cmd_ready = 1'b0; dp_next = 5'd24; dp_goal = 1'b1;
    pulse_key(1'b1, 1'b0, 5'd12);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.cmd_valid, bus.cmd_mode, bus.cmd_state} !== {1'b1, 1'b0, 5'd12}) begin
        miscompares++;
        $display("FAIL cmd_stall cycle %0d: valid %0d mode %0d state %0d want 1 0 12", i, bus.cmd_valid, bus.cmd_mode, bus.cmd_state);
      end
      // Inject a spurious completion and stray key presses while the command waits
      if (i == 2) begin dp_spur = 1'b1; dp_next = 5'd20; end
      if (i == 3) begin dp_spur = 1'b0; dp_next = 5'd24; end
      if (i == 5) begin bus.start_i = 1'b1; bus.next_i = 1'b1; bus.start_location = 5'd5; end
      if (i == 6) begin bus.start_i = 1'b0; bus.next_i = 1'b0; end
    end
    vectors++; if (n_real != 0) begin miscompares++; $display("FAIL stall_no_transfer: got %0d want 0", n_real); end
    vectors++; if (bus.state_o !== 5'd12) begin miscompares++; $display("FAIL spurious_state_o: got %0d want 12", bus.state_o); end
    vectors++; if (bus.episode_cnt !== 8'd3) begin miscompares++; $display("FAIL spurious_episode_cnt: got %0d want 3", bus.episode_cnt); end
    @(posedge clk); #1; bus.cmd_ready = 1'b1;
    wait_report(100, cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stall_report_timeout: report_valid never rose within %0d cycles", cyc); end
    vectors++; if (n_real != 1) begin miscompares++; $display("FAIL stall_one_transfer: got %0d want 1", n_real); end
    vectors++; if (first_real != 12) begin miscompares++; $display("FAIL stall_real_state: got %0d want 12", first_real); end
    vectors++; if (bus.report_data !== 8'd1) begin miscompares++; $display("FAIL stall_report_data: got %0d want 1", bus.report_data); end
    vectors++; if (bus.state_o !== 5'd24) begin miscompares++; $display("FAIL stall_state_o: got %0d want 24", bus.state_o); end
    accept_report();
    vectors++; if (bus.episode_cnt !== 8'd4) begin miscompares++; $display("FAIL stall_episode_cnt: got %0d want 4", bus.episode_cnt); end
  endtask

  task automatic test_reset_mid_plan();
    int cyc; bit ok, found;
    clear_log(); dp_next = 5'd3; dp_goal = 1'b0; bus.cmd_ready = 1'b1;
    pulse_key(1'b1, 1'b0, 5'd9);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = (bus.cmd_valid === 1'b1) && (bus.cmd_mode === 1'b1);
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL plan_issue_timeout: no planning command within 50 cycles"); end
    @(posedge clk); #1;
    vectors++; if ({bus.busy, bus.cmd_valid} !== 2'b10) begin miscompares++; $display("FAIL plan_wait_entry: busy %0d cmd_valid %0d want 1 0", bus.busy, bus.cmd_valid); end
    reset = 1'b1; #1;
    vectors++; if (bus.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_cmd_valid: got %0d want 0", bus.cmd_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %0d want 0", bus.busy); end
    vectors++; if (bus.episode_cnt !== 8'd0) begin miscompares++; $display("FAIL midreset_episode_cnt: got %0d want 0", bus.episode_cnt); end
    vectors++; if (bus.state_o !== 5'd0) begin miscompares++; $display("FAIL midreset_state_o: got %0d want 0", bus.state_o); end
    @(posedge clk); #1; reset = 1'b0;
    clear_log(); dp_next = 5'd11; dp_goal = 1'b1;
    pulse_key(1'b1, 1'b0, 5'd2);
    vectors++; if (bus.cmd_state !== 5'd2) begin miscompares++; $display("FAIL fresh_cmd_state: got %0d want 2", bus.cmd_state); end
    wait_report(100, cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fresh_report_timeout: report_valid never rose within %0d cycles", cyc); end
    vectors++; if (n_plan != 5) begin miscompares++; $display("FAIL fresh_plan_cmds: got %0d want 5", n_plan); end
    vectors++; if (bus.report_data !== 8'd1) begin miscompares++; $display("FAIL fresh_report_data: got %0d want 1", bus.report_data); end
    accept_report();
    vectors++; if (bus.episode_cnt !== 8'd1) begin miscompares++; $display("FAIL fresh_episode_cnt: got %0d want 1", bus.episode_cnt); end
  endtask

  initial begin
    test_reset();
    test_goal_first_step();
    test_step_budget();
    test_clamp_restart();
    test_ready_stall();
    test_reset_mid_plan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
